mod_count_checker: RTL

Passive monitor that sits on the output of a mod-N enable counter (e.g. the mod-12 counter) and checks the count stream it produces. It predicts the next legal value from the enable the counter sees, flags mismatches and out-of-range values, counts wraps and errors, and re-locks after an error. It is used both in benches and as an on-chip self-check next to the counter.

---
 rtl/mod_count_checker.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mod_count_checker.sv
// mod_count_checker: passive monitor for a mod-N enable counter.
// Predicts the next legal count from the shared enable, flags mismatches and
// out-of-range samples, keeps saturating wrap/error counts, captures the first
// bad sample, and re-locks onto the observed count after an error.
//
// Observation contract: there is no valid/ready handshake. Every rising edge
// of clk is one sample; count is the counter's value before that same edge's
// update, and enable is the value the counter samples at that edge.
module mod_count_checker #(
    parameter int MODULUS = 12,
    parameter int WIDTH   = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] count,
    input  logic             clear,
    output logic             locked,
    output logic             error,
    output logic             range_err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count,
    output logic [WIDTH-1:0] first_bad,
    output logic [WIDTH-1:0] first_exp
);

    // TRACK: prediction valid and compared. RESYNC: waiting for an in-range
    // value to adopt. The state is visible on locked (1 = TRACK).
    typedef enum logic {
        ST_TRACK  = 1'b0,
        ST_RESYNC = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             locked_q, locked_d;
    logic             error_q, error_d;
    logic             range_q, range_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [WIDTH-1:0] first_bad_q, first_bad_d;
    logic [WIDTH-1:0] first_exp_q, first_exp_d;

    logic in_range;
    logic bad_ev;
    logic wrap_ev;

    assign in_range = (32'(count) < 32'(MODULUS));

    // Legal successor of a count value: wraps from MODULUS-1 back to 0.
    function automatic logic [WIDTH-1:0] inc_mod(input logic [WIDTH-1:0] x);
        return (x == LAST) ? '0 : x + 1'b1;
    endfunction

    // Saturating increment: sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == CNT_MAX) ? x : x + 1'b1;
    endfunction

    // Next-state logic: clear zeroes the status first, then this edge's
    // error or wrap event is applied on top of the cleared values.
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        locked_d    = locked_q;
        error_d     = clear ? 1'b0 : error_q;
        range_d     = clear ? 1'b0 : range_q;
        err_cnt_d   = clear ? '0 : err_cnt_q;
        wrap_cnt_d  = clear ? '0 : wrap_cnt_q;
        first_bad_d = clear ? '0 : first_bad_q;
        first_exp_d = clear ? '0 : first_exp_q;
        bad_ev      = 1'b0;
        wrap_ev     = 1'b0;

        case (state_q)
            ST_TRACK: begin
                if (in_range && (count == exp_q)) begin
                    if (enable) begin
                        exp_d = inc_mod(exp_q);
                    end
                    wrap_ev = enable && (count == LAST);
                end else begin
                    bad_ev   = 1'b1;
                    state_d  = ST_RESYNC;
                    locked_d = 1'b0;
                end
            end
            ST_RESYNC: begin
                if (in_range) begin
                    exp_d    = enable ? inc_mod(count) : count;
                    state_d  = ST_TRACK;
                    locked_d = 1'b1;
                end else begin
                    bad_ev = 1'b1;
                end
            end
            default: begin
                state_d  = ST_TRACK;
                locked_d = 1'b1;
            end
        endcase

        if (wrap_ev) begin
            wrap_cnt_d = sat_inc(wrap_cnt_d);
        end

        if (bad_ev) begin
            // Capture only the first bad sample since reset or clear.
            if (!error_d) begin
                first_bad_d = count;
                first_exp_d = (state_q == ST_TRACK) ? exp_q : '0;
            end
            error_d   = 1'b1;
            err_cnt_d = sat_inc(err_cnt_d);
            if (!in_range) begin
                range_d = 1'b1;
            end
        end
    end

    // State and status registers; reset returns to a locked prediction of 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_TRACK;
            exp_q       <= '0;
            locked_q    <= 1'b1;
            error_q     <= 1'b0;
            range_q     <= 1'b0;
            err_cnt_q   <= '0;
            wrap_cnt_q  <= '0;
            first_bad_q <= '0;
            first_exp_q <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            locked_q    <= locked_d;
            error_q     <= error_d;
            range_q     <= range_d;
            err_cnt_q   <= err_cnt_d;
            wrap_cnt_q  <= wrap_cnt_d;
            first_bad_q <= first_bad_d;
            first_exp_q <= first_exp_d;
        end
    end

    assign locked     = locked_q;
    assign error      = error_q;
    assign range_err  = range_q;
    assign err_count  = err_cnt_q;
    assign wrap_count = wrap_cnt_q;
    assign first_bad  = first_bad_q;
    assign first_exp  = first_exp_q;

endmodule
